// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with burst sequencer; direct modes take effect on the next edge, and A/D/start are ignored while busy or done.
// Optional USR_ROTATE_EN: ROT=1 feeds the wrapped bit back instead of DL/DR (ROT is latched with start for bursts).
module univ_shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       A,
    input  logic             ROT,
    input  logic [WIDTH-1:0] D,
    input  logic             DL,
    input  logic             DR,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             dir_left;
    logic             rot_direct;
    logic             rot_burst;
    logic             burst_req;

`ifdef USR_ROTATE_EN
    logic rot_lat;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rot_lat <= 1'b0;
        end else if (state == ST_IDLE && burst_req) begin
            rot_lat <= ROT;
        end
    end

    assign rot_direct = ROT;
    assign rot_burst  = rot_lat;
`else
    logic unused_rot;

    assign unused_rot = ROT;
    assign rot_direct = 1'b0;
    assign rot_burst  = 1'b0;
`endif

    assign burst_req = start && (A == MODE_RIGHT || A == MODE_LEFT);

    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] cur,
        input logic             left,
        input logic             rot,
        input logic             dl,
        input logic             dr
    );
        if (left) begin
            return {cur[WIDTH-2:0], rot ? cur[WIDTH-1] : dl};
        end
        return {rot ? cur[0] : dr, cur[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            Q         <= '0;
            remaining <= '0;
            dir_left  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (burst_req) begin
                        // The accepting edge only latches the burst; the first shift happens on the next edge.
                        dir_left  <= (A == MODE_LEFT);
                        remaining <= count;
                        state     <= (count == '0) ? ST_DONE : ST_SHIFT;
                    end else begin
                        case (A)
                            MODE_RIGHT: Q <= shift_step(Q, 1'b0, rot_direct, DL, DR);
                            MODE_LEFT:  Q <= shift_step(Q, 1'b1, rot_direct, DL, DR);
                            MODE_LOAD:  Q <= D;
                            MODE_HOLD:  Q <= Q;
                            default:    Q <= Q;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    Q <= shift_step(Q, dir_left, rot_burst, DL, DR);
                    if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (remaining <= CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
    assign SO_R = Q[0];
    assign SO_L = Q[WIDTH-1];

endmodule
